// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and transmit-sequencer state encoding.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_START = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE       = ST_IDLE,
    S_WAIT_START = ST_WAIT_START,
    S_WAIT_DONE  = ST_WAIT_DONE
  } tx_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with an explicit occupancy counter.
// A push while full is dropped and flagged on o_Drop for that cycle.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic                   i_Push,
  input  logic [UART_DATA_W-1:0] i_Data,
  input  logic                   i_Pop,
  output logic [UART_DATA_W-1:0] o_Head,
  output logic [ADDR_W:0]        o_Count,
  output logic                   o_Full,
  output logic                   o_Empty,
  output logic                   o_Drop
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [UART_DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]      r_wr_ptr;
  logic [ADDR_W-1:0]      r_rd_ptr;
  logic [ADDR_W:0]        r_count;
  logic                   r_full;
  logic                   r_empty;

  logic                   w_push_ok;
  logic                   w_pop_ok;
  logic [ADDR_W:0]        w_count_next;

  // Fullness/emptiness are the registered values from before the edge.
  assign w_push_ok = i_Push && !r_full;
  assign w_pop_ok  = i_Pop && !r_empty;

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    w_count_next = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_next = r_count + CNT_ONE;
      2'b01:   w_count_next = r_count - CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  // Pointers, counter and decoded flags; pointers wrap naturally at DEPTH.
  always_ff @(posedge i_Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count <= w_count_next;
      r_full  <= (w_count_next == CNT_FULL);
      r_empty <= (w_count_next == '0);
    end
  end

  // Storage write port.
  always_ff @(posedge i_Clock) begin
    // NOTE: storage is deliberately not reset; reset pointers make stale contents unreachable.
    if (w_push_ok) r_mem[r_wr_ptr] <= i_Data;
  end

  assign o_Head  = r_mem[r_rd_ptr];
  assign o_Count = r_count;
  assign o_Full  = r_full;
  assign o_Empty = r_empty;
  assign o_Drop  = i_Push && r_full;

endmodule

// File: rtl/uart_echo_buffer.sv
// Buffers bytes from uart_rx and launches them into uart_tx one frame at a time,
// waiting for the transmitter to be fully idle (not active, not done) before each launch.
module uart_echo_buffer
  import uart_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic                   i_Rx_DV,
  input  logic [UART_DATA_W-1:0] i_Rx_Byte,
  input  logic                   i_Tx_Active,
  input  logic                   i_Tx_Done,
  output logic                   o_Tx_DV,
  output logic [UART_DATA_W-1:0] o_Tx_Byte,
  output logic [ADDR_W:0]        o_Count,
  output logic                   o_Empty,
  output logic                   o_Full,
  output logic                   o_Overflow
);

  tx_state_e              r_state;
  tx_state_e              w_state_next;
  logic                   w_launch;
  logic                   w_empty;
  logic                   w_drop;
  logic [UART_DATA_W-1:0] w_head;

  logic                   r_tx_dv;
  logic [UART_DATA_W-1:0] r_tx_byte;
  logic                   r_overflow;

  uart_byte_fifo #(
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Push  (i_Rx_DV),
    .i_Data  (i_Rx_Byte),
    .i_Pop   (w_launch),
    .o_Head  (w_head),
    .o_Count (o_Count),
    .o_Full  (o_Full),
    .o_Empty (w_empty),
    .o_Drop  (w_drop)
  );

  // Transmit sequencer state register.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Next state and launch decision; a launch pops the FIFO head on the same edge.
  always_comb begin
    w_state_next = r_state;
    w_launch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && !i_Tx_Active && !i_Tx_Done) begin
          w_launch     = 1'b1;
          w_state_next = S_WAIT_START;
        end
      end
      S_WAIT_START: if (i_Tx_Active) w_state_next = S_WAIT_DONE;
      S_WAIT_DONE:  if (i_Tx_Done)   w_state_next = S_IDLE;
      default:      w_state_next = S_IDLE;
    endcase
  end

  // Registered launch pulse, held launch byte and sticky overflow flag.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_tx_dv    <= 1'b0;
      r_tx_byte  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_tx_dv <= w_launch;
      if (w_launch) r_tx_byte <= w_head;
      if (w_drop)   r_overflow <= 1'b1;
    end
  end

  assign o_Tx_DV    = r_tx_dv;
  assign o_Tx_Byte  = r_tx_byte;
  assign o_Empty    = w_empty;
  assign o_Overflow = r_overflow;

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Scoreboard bench for uart_echo_buffer: a queue-based FIFO image predicts
// occupancy, drops and launch order; a monitor compares every cycle.
module tb_uart_echo_buffer;
  import uart_pkg::*;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;
  localparam int FRAME  = 10;

  logic             clk;
  logic             i_Reset;
  logic             i_Rx_DV;
  logic [7:0]       i_Rx_Byte;
  logic             tx_active;
  logic             tx_done;
  logic             o_Tx_DV;
  logic [7:0]       o_Tx_Byte;
  logic [ADDR_W:0]  o_Count;
  logic             o_Empty;
  logic             o_Full;
  logic             o_Overflow;

  // Transmitter status: either a timed model or direct drive from the stimulus.
  logic auto_tx, m_active, m_done, d_active, d_done;
  assign tx_active = auto_tx ? m_active : d_active;
  assign tx_done   = auto_tx ? m_done   : d_done;

  uart_echo_buffer #(.ADDR_W(ADDR_W)) dut (
    .i_Clock     (clk),
    .i_Reset     (i_Reset),
    .i_Rx_DV     (i_Rx_DV),
    .i_Rx_Byte   (i_Rx_Byte),
    .i_Tx_Active (tx_active),
    .i_Tx_Done   (tx_done),
    .o_Tx_DV     (o_Tx_DV),
    .o_Tx_Byte   (o_Tx_Byte),
    .o_Count     (o_Count),
    .o_Empty     (o_Empty),
    .o_Full      (o_Full),
    .o_Overflow  (o_Overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int n_launch = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs as seen by the DUT at each rising edge.
  logic       s_reset = 1'b1;
  logic       s_rx_dv = 1'b0;
  logic [7:0] s_rx_byte = 8'h00;
  logic       s_active = 1'b0;
  logic       s_done = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      s_reset   = i_Reset;
      s_rx_dv   = i_Rx_DV;
      s_rx_byte = i_Rx_Byte;
      s_active  = tx_active;
      s_done    = tx_done;
    end
  end

  // Reference model + monitor: FIFO image as a queue, compared mid-cycle.
  logic [7:0] model_q[$];
  initial begin
    logic       exp_ovf;
    logic [7:0] last_byte;
    logic       prev_dv;
    logic       full_before;
    exp_ovf   = 1'b0;
    last_byte = 8'h00;
    prev_dv   = 1'b0;
    forever begin
      @(negedge clk);
      if (s_reset) begin
        model_q.delete();
        exp_ovf   = 1'b0;
        last_byte = 8'h00;
        check("reset_tx_dv", o_Tx_DV, 0);
      end else begin
        full_before = (model_q.size() == DEPTH);
        if (o_Tx_DV) begin
          n_launch++;
          check("launch_single_pulse", prev_dv, 0);
          check("launch_tx_idle", {s_active, s_done}, 0);
          check("launch_nonempty", model_q.size() != 0, 1);
          if (model_q.size() != 0) last_byte = model_q.pop_front();
        end
        if (s_rx_dv) begin
          if (full_before) exp_ovf = 1'b1;
          else             model_q.push_back(s_rx_byte);
        end
      end
      check("tx_byte", o_Tx_Byte, last_byte);
      check("count", o_Count, model_q.size());
      check("empty", o_Empty, model_q.size() == 0);
      check("full", o_Full, model_q.size() == DEPTH);
      check("overflow", o_Overflow, exp_ovf);
      prev_dv = o_Tx_DV;
    end
  end

  // Timed transmitter: active for FRAME cycles after a launch, then done for 2 cycles.
  initial begin
    m_active = 1'b0;
    m_done   = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_tx && o_Tx_DV) begin
        m_active = 1'b1;
        repeat (FRAME) @(negedge clk);
        m_active = 1'b0;
        m_done   = 1'b1;
        repeat (2) @(negedge clk);
        m_done   = 1'b0;
      end
    end
  end

  // All stimulus changes land 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    i_Rx_DV   = 1'b1;
    i_Rx_Byte = b;
    tick();
    i_Rx_DV   = 1'b0;
  endtask

  task automatic do_reset();
    i_Reset = 1'b1;
    tick();
    tick();
    i_Reset = 1'b0;
  endtask

  task automatic wait_launch(input string name, input int budget);
    int  k;
    logic got;
    k   = 0;
    got = 1'b0;
    while (k < budget && !got) begin
      @(negedge clk);
      if (o_Tx_DV) got = 1'b1;
      k++;
    end
    check(name, got, 1);
    tick();
  endtask

  task automatic manual_frame(input string name);
    wait_launch(name, 20);
    d_active = 1'b1;
    repeat (3) tick();
    d_active = 1'b0;
    d_done   = 1'b1;
    tick();
    d_done   = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (k < 300 && !(o_Empty && !tx_active && !tx_done && !o_Tx_DV)) begin
      tick();
      k++;
    end
    check(name, k < 300, 1);
  endtask

  initial begin
    int n0;
    i_Reset   = 1'b1;
    i_Rx_DV   = 1'b0;
    i_Rx_Byte = 8'h00;
    auto_tx   = 1'b0;
    d_active  = 1'b0;
    d_done    = 1'b0;
    tick();
    do_reset();
    check("rst_count", o_Count, 0);
    check("rst_empty", o_Empty, 1);
    check("rst_tx_byte", o_Tx_Byte, 8'h00);

    // Single byte: launch exactly two cycles after the receive pulse.
    push(8'hA5);
    @(negedge clk);
    check("lat_n1_dv", o_Tx_DV, 0);
    @(negedge clk);
    check("lat_n2_dv", o_Tx_DV, 1);
    check("lat_n2_byte", o_Tx_Byte, 8'hA5);
    check("lat_n2_count", o_Count, 0);
    @(negedge clk);
    check("lat_n3_dv", o_Tx_DV, 0);
    tick();
    d_active = 1'b1;
    repeat (3) tick();
    d_active = 1'b0;
    d_done   = 1'b1;
    tick();
    d_done   = 1'b0;

    // Burst while the transmitter is busy.
    d_active = 1'b1;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    tick();
    check("burst_count", o_Count, 3);
    n0 = n_launch;
    d_active = 1'b0;
    repeat (3) manual_frame("burst_launch");
    repeat (5) tick();
    check("burst_launches", n_launch - n0, 3);
    check("burst_empty", o_Empty, 1);

    // Overflow with a 4-deep FIFO.
    do_reset();
    d_active = 1'b1;
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    tick();
    check("ovf_full", o_Full, 1);
    check("ovf_count", o_Count, 4);
    check("ovf_flag", o_Overflow, 1);
    d_active = 1'b0;
    repeat (4) manual_frame("ovf_launch");
    repeat (3) tick();
    check("ovf_sticky", o_Overflow, 1);
    check("ovf_drained", o_Empty, 1);
    do_reset();
    check("ovf_cleared", o_Overflow, 0);

    // Push on the same edge as a launch.
    d_active = 1'b1;
    push(8'h21);
    push(8'h22);
    d_active  = 1'b0;
    i_Rx_DV   = 1'b1;
    i_Rx_Byte = 8'h23;
    tick();
    i_Rx_DV   = 1'b0;
    check("simul_dv", o_Tx_DV, 1);
    check("simul_count", o_Count, 2);
    repeat (3) manual_frame("simul_launch");
    repeat (3) tick();

    // Reset while the transmitter is mid-frame.
    push(8'h31);
    wait_launch("mf_first", 10);
    d_active = 1'b1;
    push(8'h32);
    push(8'h33);
    push(8'h34);
    check("mf_queued", o_Count, 3);
    i_Reset = 1'b1;
    tick();
    i_Reset = 1'b0;
    check("mf_count", o_Count, 0);
    n0 = n_launch;
    push(8'h35);
    repeat (4) tick();
    d_active = 1'b0;
    d_done   = 1'b1;
    repeat (2) tick();
    check("mf_held", n_launch - n0, 0);
    d_done   = 1'b0;
    manual_frame("mf_relaunch");
    push(8'h36);
    manual_frame("mf_next");
    repeat (3) tick();
    check("mf_launches", n_launch - n0, 2);

    // Pointer wrap: 3*16 sequential bytes through the timed transmitter.
    do_reset();
    auto_tx = 1'b1;
    n0 = n_launch;
    for (int i = 0; i < 48; i++) begin
      push(8'(i));
      repeat ($urandom_range(14, 18)) tick();
    end
    drain("wrap_drain");
    check("wrap_launches", n_launch - n0, 48);
    check("wrap_no_overflow", o_Overflow, 0);

    // Random traffic faster than the transmitter, including drops.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) push(8'($urandom));
      else                           tick();
    end
    drain("rand_drain");
    check("rand_queue_empty", model_q.size(), 0);
    auto_tx = 1'b0;
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_echo_buffer.md
# uart_echo_buffer

Byte buffer and transmit sequencer between `uart_rx` and `uart_tx` in the UART loopback path. It accepts each received byte on the receiver's one-cycle data-valid pulse and stores it in a FIFO. It launches stored bytes into the transmitter one at a time, honouring the transmitter's busy and done status. Back-to-back received frames are therefore never lost while the transmitter is busy. It replaces the direct `Rx_DV`/`Rx_Byte` → `Tx_DV`/`Tx_Byte` connection in `top`.

## Interface
- `ADDR_W`, default 4: FIFO address width. Depth is `DEPTH = 2**ADDR_W` (16 at default). Minimum value 1.
- `i_Clock`  in  1  system clock, the same clock as `uart_rx`/`uart_tx`.
- `i_Reset`  in  1  synchronous, active-high reset.
- `i_Rx_DV`  in  1  one-cycle byte-valid pulse from `uart_rx` `o_Rx_DV`.
- `i_Rx_Byte`  in  8  received byte, valid while `i_Rx_DV`=1.
- `i_Tx_Active`  in  1  from `uart_tx` `o_Tx_Active`.
- `i_Tx_Done`  in  1  from `uart_tx` `o_Tx_Done`.
- `o_Tx_DV`  out  1  one-cycle launch pulse to `uart_tx` `i_Tx_DV`.
- `o_Tx_Byte`  out  8  byte to `uart_tx`. Holds the last launched byte.
- `o_Count`  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH.
- `o_Empty`  out  1  `o_Count`==0.
- `o_Full`  out  1  `o_Count`==DEPTH.
- `o_Overflow`  out  1  sticky flag: a byte was dropped because the FIFO was full.

## Operation
- **Push:** on a rising edge with `i_Rx_DV`=1 and not full, write `i_Rx_Byte` at the write pointer. The write pointer advances modulo DEPTH.
- **Push while full:** the byte is dropped and `o_Overflow` is set to 1. `o_Overflow` clears only on `i_Reset`. Fullness is evaluated before the edge, so a push while full is dropped even if a pop happens in the same cycle.
- **Simultaneous push and pop, not full:** both occur and `o_Count` is unchanged.
- **Pointers:** wrap from DEPTH-1 to 0. Occupancy is held in an explicit ADDR_W+1-bit counter. `o_Full` and `o_Empty` are decoded from that counter.
- **Transmit FSM states:** IDLE, WAIT_START, WAIT_DONE.
  - IDLE → WAIT_START when !empty && !`i_Tx_Active` && !`i_Tx_Done`. On that edge: pop the head byte, register it into `o_Tx_Byte`, and set `o_Tx_DV`=1.
  - WAIT_START: `o_Tx_DV` returns to 0. Go to WAIT_DONE when `i_Tx_Active`=1.
  - WAIT_DONE → IDLE on `i_Tx_Done`=1.
- Exactly one `o_Tx_DV` pulse is issued per popped byte. `o_Tx_DV` is never asserted outside the IDLE→WAIT_START transition.
- IDLE also waits for `i_Tx_Done`=0. This absorbs the transmitter's multi-cycle done indication and any frame still in flight after reset.
- **Reset:** pointers, counter and `o_Overflow` clear, and the FSM goes to IDLE. FIFO storage is not cleared.
- **Reset mid-frame:** if the transmitter is mid-frame when reset is applied, the block launches nothing until `i_Tx_Active` and `i_Tx_Done` are both low.

## Timing
- **Reset values:** `o_Tx_DV`=0, `o_Tx_Byte`=8'h00, `o_Count`=0, `o_Empty`=1, `o_Full`=0, `o_Overflow`=0.
- **Status update:** `o_Count`, `o_Empty` and `o_Full` update on the edge that samples the push or pop.
- **Latency:** if `i_Rx_DV` is high in cycle N with an empty FIFO and an idle transmitter, `o_Tx_DV` is high in cycle N+2 and `o_Tx_Byte` is valid from that cycle. There is no combinational bypass.
- **Pop timing:** occupancy drops on the launch edge, not on `i_Tx_Done`.
- **Throughput:** one byte per transmitter frame, plus at most 2 cycles of gap after `i_Tx_Done` falls.
- **Outputs:** all outputs are registered.

## Structure
- Shared package `uart_pkg` holds:
  - the `UART_DATA_W`=8 constant;
  - the FSM state encoding localparams `ST_IDLE`=2'd0, `ST_WAIT_START`=2'd1, `ST_WAIT_DONE`=2'd2.
- One sub-module, `uart_byte_fifo`: a synchronous FIFO with push, pop, count, full, empty and drop-on-full. The FSM and overflow flag live in `uart_echo_buffer`.
- `top` gains a reset input and instantiates `uart_echo_buffer` between `top_uart_rx` and `top_uart_tx`.

## Test plan
- **Single byte:** after reset, pulse `i_Rx_DV` with 8'hA5 in cycle N, transmitter idle → `o_Tx_DV`=1 with `o_Tx_Byte`=8'hA5 in cycle N+2 only, `o_Count` back to 0.
- **Burst while busy:** hold `i_Tx_Active`=1 and push 8'h01, 8'h02, 8'h03 → `o_Count`=3. Then pulse `i_Tx_Done` three times → exactly three launches, in order 01, 02, 03, and `o_Empty`=1 at the end.
- **Overflow (ADDR_W=2):** push 5 bytes with the transmitter busy → `o_Full`=1, `o_Count`=4, the 5th byte is dropped, and `o_Overflow` stays 1 until reset.
- **Simultaneous push/pop:** FIFO holds 2 bytes; push in the same cycle as the IDLE launch → `o_Count` stays 2 and the FIFO ordering is preserved.
- **Reset mid-frame:** assert `i_Reset` in WAIT_DONE while `i_Tx_Active`=1 with 3 bytes queued → `o_Count`=0 and no `o_Tx_DV` until `i_Tx_Active` and `i_Tx_Done` are both low. A subsequent push launches normally.
- **Pointer wrap:** stream 3×DEPTH bytes 0x00..0x2F through with a modelled 10-cycle transmitter → output sequence identical to input, no overflow.
